// File: rtl/svo_hdmi_sched_if.sv
// Signal bundle between the timing/pixel source, the HDMI scheduler and the
// three TMDS encoders plus the downstream guard-band mux.
interface svo_hdmi_sched_if;
  logic        in_de;
  logic        in_hsync;
  logic        in_vsync;
  logic [23:0] in_pixel;

  logic        enc_de;
  logic [1:0]  enc_ctrl0;
  logic [1:0]  enc_ctrl1;
  logic [1:0]  enc_ctrl2;
  logic [7:0]  enc_din0;
  logic [7:0]  enc_din1;
  logic [7:0]  enc_din2;
  logic        gb_force;
  logic [9:0]  gb_code0;
  logic [9:0]  gb_code1;
  logic [9:0]  gb_code2;
  logic        short_blank;

  modport master (
    output in_de, in_hsync, in_vsync, in_pixel,
    input  enc_de, enc_ctrl0, enc_ctrl1, enc_ctrl2, enc_din0, enc_din1, enc_din2,
    input  gb_force, gb_code0, gb_code1, gb_code2, short_blank
  );

  modport slave (
    input  in_de, in_hsync, in_vsync, in_pixel,
    output enc_de, enc_ctrl0, enc_ctrl1, enc_ctrl2, enc_din0, enc_din1, enc_din2,
    output gb_force, gb_code0, gb_code1, gb_code2, short_blank
  );
endinterface

// File: rtl/svo_hdmi_sched.sv
// HDMI video-period scheduler: delays timing/pixels by PRE_LEN+GB_LEN clocks and
// inserts the CTL preamble and leading guard band ahead of every active line.
module svo_hdmi_sched #(
  parameter int unsigned PRE_LEN = 8,
  parameter int unsigned GB_LEN  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               dvi_mode,
  svo_hdmi_sched_if.slave    bus
);

  localparam int unsigned L    = PRE_LEN + GB_LEN;
  localparam int unsigned CntW = $clog2(L + 1);
  localparam logic [CntW-1:0] LCnt  = CntW'(L);
  localparam logic [CntW-1:0] GbCnt = CntW'(GB_LEN);
  localparam logic [CntW-1:0] One   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StPre, StGuard, StActive} state_e;

  // Each delay stage holds {de, vsync, hsync, pixel}.
  logic [L-1:0][26:0] dly_q;
  logic [26:0]        tap;
  logic               d_de, d_vs, d_hs;
  logic [23:0]        d_pix;

  logic               prev_de_q;
  logic               rise;
  state_e             state_q, state_d;
  logic [CntW-1:0]    lead_q, lead_d;

  logic               de_q, de_d;
  logic [1:0]         ctrl0_q, ctrl0_d, ctrl1_q, ctrl1_d;
  logic [23:0]        din_q, din_d;
  logic               gb_q, gb_d;
  logic               sb_q, sb_d;

  assign tap   = dly_q[L-1];
  assign d_de  = tap[26];
  assign d_vs  = tap[25];
  assign d_hs  = tap[24];
  assign d_pix = tap[23:0];
  assign rise  = bus.in_de & ~prev_de_q;

  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    if (lead_q != '0) lead_d = lead_q - One;
    case (state_q)
      StPre:    if (lead_d == GbCnt) state_d = StGuard;
      StGuard:  if (lead_d == '0) state_d = StActive;
      StActive: if (!d_de) state_d = StIdle;
      default:  ;
    endcase
    if (rise && !dvi_mode) begin
      lead_d  = LCnt;
      state_d = StPre;
    end
  end

  always_comb begin
    de_d    = d_de;
    ctrl0_d = {d_vs, d_hs};
    ctrl1_d = 2'b00;
    gb_d    = 1'b0;
    din_d   = din_q;
    if (d_de) begin
      din_d = d_pix;
    end else if (state_q == StGuard) begin
      gb_d = 1'b1;
    end else if (state_q == StPre) begin
      ctrl1_d = 2'b01;
    end
    // The last guard cycle always coincides with the line's own first pixel;
    // delayed video any earlier in the lead-in belongs to the previous line.
    sb_d = sb_q | (d_de & (lead_q > One));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dly_q     <= '0;
      prev_de_q <= 1'b0;
      state_q   <= StIdle;
      lead_q    <= '0;
      de_q      <= 1'b0;
      ctrl0_q   <= 2'b00;
      ctrl1_q   <= 2'b00;
      din_q     <= '0;
      gb_q      <= 1'b0;
      sb_q      <= 1'b0;
    end else begin
      dly_q     <= {dly_q[L-2:0], {bus.in_de, bus.in_vsync, bus.in_hsync, bus.in_pixel}};
      prev_de_q <= bus.in_de;
      state_q   <= state_d;
      lead_q    <= lead_d;
      de_q      <= de_d;
      ctrl0_q   <= ctrl0_d;
      ctrl1_q   <= ctrl1_d;
      din_q     <= din_d;
      gb_q      <= gb_d;
      sb_q      <= sb_d;
    end
  end

  assign bus.enc_de      = de_q;
  assign bus.enc_ctrl0   = ctrl0_q;
  assign bus.enc_ctrl1   = ctrl1_q;
  assign bus.enc_ctrl2   = 2'b00;
  assign bus.enc_din0    = din_q[7:0];
  assign bus.enc_din1    = din_q[15:8];
  assign bus.enc_din2    = din_q[23:16];
  assign bus.gb_force    = gb_q;
  assign bus.gb_code0    = 10'b1011001100;
  assign bus.gb_code1    = 10'b0100110011;
  assign bus.gb_code2    = 10'b1011001100;
  assign bus.short_blank = sb_q;

endmodule

// File: tb/tb_svo_hdmi_sched.sv
// Bench for svo_hdmi_sched: directed line scenarios plus random lines, checked
// against a model that tracks input history and distance from the last rise.
module tb_svo_hdmi_sched;
  localparam int PreLen = 8;
  localparam int GbLen  = 2;
  localparam int L      = PreLen + GbLen;

  logic  clk = 1'b0;
  logic  resetn = 1'b0;
  logic  dvi_mode = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  string phase = "reset";

  svo_hdmi_sched_if bus ();

  svo_hdmi_sched #(.PRE_LEN(PreLen), .GB_LEN(GbLen)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .dvi_mode (dvi_mode),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Model state: last L sampled inputs, edge index of the last HDMI rise.
  logic [26:0] hist[$];
  int          e_idx;
  int          last_rise;
  logic        m_prev_de;
  logic [23:0] m_din;
  logic        m_sb;

  function automatic logic [32:0] obs_vec();
    return {bus.enc_de, bus.gb_force, bus.enc_ctrl0, bus.enc_ctrl1, bus.enc_ctrl2,
            bus.enc_din2, bus.enc_din1, bus.enc_din0, bus.short_blank};
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < L; i++) hist.push_back(27'd0);
    last_rise = -1000;
    m_prev_de = 1'b0;
    m_din     = '0;
    m_sb      = 1'b0;
  endtask

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] pix);
    logic [26:0] d;
    logic        rise, pre, guard, gb;
    logic [1:0]  c1;
    int          j;
    bus.in_de    = de;
    bus.in_hsync = hs;
    bus.in_vsync = vs;
    bus.in_pixel = pix;
    @(posedge clk);
    #1;
    d = hist.pop_front();
    hist.push_back({de, vs, hs, pix});
    j     = e_idx - last_rise;
    rise  = de && !m_prev_de;
    m_prev_de = de;
    pre   = (j >= 1) && (j <= PreLen);
    guard = (j > PreLen) && (j <= L);
    gb    = !d[26] && guard;
    c1    = (!d[26] && !guard && pre) ? 2'b01 : 2'b00;
    if (d[26]) m_din = d[23:0];
    if (d[26] && j >= 1 && j < L) m_sb = 1'b1;
    if (rise && !dvi_mode) last_rise = e_idx;
    e_idx++;
    check(phase, obs_vec(), {d[26], gb, d[25:24], c1, 2'b00, m_din, m_sb});
  endtask

  task automatic run(input logic de, input int n);
    for (int i = 0; i < n; i++)
      step(de, 1'($urandom), 1'($urandom), 24'($urandom));
  endtask

  task automatic line(input int blank, input int active);
    run(1'b0, blank);
    run(1'b1, active);
  endtask

  task automatic async_reset();
    #2 resetn = 1'b0;
    #1 check({phase, "_async"}, obs_vec(), 33'd0);
    repeat (3) @(posedge clk);
    #1 check({phase, "_held"}, obs_vec(), 33'd0);
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.in_de    = 1'b0;
    bus.in_hsync = 1'b0;
    bus.in_vsync = 1'b0;
    bus.in_pixel = '0;
    e_idx = 0;
    model_reset();
    #2;
    check("reset_out", obs_vec(), 33'd0);
    n_tests++;
    assert (bus.gb_code0 === 10'b1011001100 && bus.gb_code1 === 10'b0100110011 &&
            bus.gb_code2 === 10'b1011001100) else begin
      n_fail++;
      $error("FAIL gb_code: observed %h %h %h expected 2cc 133 2cc",
             bus.gb_code0, bus.gb_code1, bus.gb_code2);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    phase = "hdmi_line";
    run(1'b0, 80);
    line(20, 16);
    run(1'b0, 20);

    phase = "dvi_line";
    dvi_mode = 1'b1;
    line(20, 16);
    run(1'b0, 20);
    dvi_mode = 1'b0;

    phase = "short_blank";
    line(20, 16);
    line(6, 16);
    run(1'b0, 20);

    phase = "reset_mid_pre";
    run(1'b0, 20);
    run(1'b1, 4);
    async_reset();
    phase = "after_reset";
    line(2, 16);
    run(1'b0, 20);

    phase = "restart";
    step(1'b1, 1'b0, 1'b1, 24'h112233);
    step(1'b0, 1'b1, 1'b0, 24'h445566);
    step(1'b1, 1'b1, 1'b1, 24'h778899);
    run(1'b1, 15);
    run(1'b0, 20);

    phase = "random";
    for (int n = 0; n < 60; n++) begin
      if (($urandom % 4) == 0) dvi_mode = ~dvi_mode;
      line($urandom_range(1, 24), $urandom_range(1, 20));
    end
    run(1'b0, 20);

    phase = "random_reset";
    line(3, 5);
    run(1'b0, 2);
    run(1'b1, 2);
    async_reset();
    dvi_mode = 1'b0;
    for (int n = 0; n < 20; n++) line($urandom_range(1, 24), $urandom_range(1, 20));
    run(1'b0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
